// File: rtl/m_lsu_pkg.sv
// m_lsu_pkg: shared definitions for the M-stage load/store unit.
//   - mem_op_e    : memory-operation encodings carried down the pipe
//   - EXC_*       : ExcCode values raised by this stage
//   - address map : data memory, timers and interrupt generator windows
//   - em_reg_t    : E/M pipeline register layout
//   - in_window() : half-open window test that avoids a ">= 0" compare
package m_lsu_pkg;

    typedef enum logic [3:0] {
        MOP_NONE = 4'd0,
        MOP_LW   = 4'd1,
        MOP_LH   = 4'd2,
        MOP_LHU  = 4'd3,
        MOP_LB   = 4'd4,
        MOP_LBU  = 4'd5,
        MOP_SW   = 4'd6,
        MOP_SH   = 4'd7,
        MOP_SB   = 4'd8
    } mem_op_e;

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;

    localparam logic [31:0] DM_TOP       = 32'h0000_2FFF;
    localparam logic [31:0] TC0_BASE     = 32'h0000_7F00;
    localparam logic [31:0] TC1_BASE     = 32'h0000_7F10;
    localparam logic [31:0] IG_BASE      = 32'h0000_7F20;
    localparam logic [31:0] TC_SIZE      = 32'd12;
    localparam logic [31:0] IG_SIZE      = 32'd4;
    localparam logic [31:0] TC_COUNT_OFS = 32'd8;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        mem_op_e     mem_op;
        logic [31:0] addr;
        logic        addr_ov;
        logic [31:0] wdata;
        logic [4:0]  exc_in;
    } em_reg_t;

    // True when base <= a < base + size; unsigned wrap makes a < base fail.
    function automatic logic in_window(input logic [31:0] a,
                                       input logic [31:0] base,
                                       input logic [31:0] size);
        return (a - base) < size;
    endfunction

endpackage

// File: rtl/m_lsu_if.sv
// m_lsu_if: data-bus request/response between the LSU and data memory.
//   m_data_addr   : byte address of the access
//   m_data_wdata  : lane-replicated store data
//   m_data_byteen : per-byte write enables (0 = no write)
//   m_data_rdata  : read data returned combinationally in the same cycle
interface m_lsu_if;
    logic [31:0] m_data_addr;
    logic [31:0] m_data_wdata;
    logic [3:0]  m_data_byteen;
    logic [31:0] m_data_rdata;

    modport master (
        output m_data_addr,
        output m_data_wdata,
        output m_data_byteen,
        input  m_data_rdata
    );

    modport slave (
        input  m_data_addr,
        input  m_data_wdata,
        input  m_data_byteen,
        output m_data_rdata
    );
endinterface

// File: rtl/m_lsu_check.sv
// m_lsu_check: combinational address-error decode for one memory access.
//   mem_op_i  : operation in M
//   addr_i    : byte address
//   addr_ov_i : address computation overflowed
//   adel_o    : load address error
//   ades_o    : store address error
module m_lsu_check
    import m_lsu_pkg::*;
(
    input  mem_op_e     mem_op_i,
    input  logic [31:0] addr_i,
    input  logic        addr_ov_i,
    output logic        adel_o,
    output logic        ades_o
);

    logic is_load, is_store, in_tc, legal, misalign, narrow, bad, cnt_hit;

    always_comb begin
        is_load  = mem_op_i inside {MOP_LW, MOP_LH, MOP_LHU, MOP_LB, MOP_LBU};
        is_store = mem_op_i inside {MOP_SW, MOP_SH, MOP_SB};
        in_tc    = in_window(addr_i, TC0_BASE, TC_SIZE) ||
                   in_window(addr_i, TC1_BASE, TC_SIZE);
        legal    = (addr_i <= DM_TOP) || in_tc ||
                   in_window(addr_i, IG_BASE, IG_SIZE);
        misalign = ((mem_op_i inside {MOP_LW, MOP_SW}) && (addr_i[1:0] != 2'b00)) ||
                   ((mem_op_i inside {MOP_LH, MOP_LHU, MOP_SH}) && addr_i[0]);
        // Timers only accept full-word accesses.
        narrow   = (mem_op_i inside {MOP_LH, MOP_LHU, MOP_LB, MOP_LBU, MOP_SH, MOP_SB})
                   && in_tc;
        // Timer count registers are read-only.
        cnt_hit  = (addr_i == TC0_BASE + TC_COUNT_OFS) ||
                   (addr_i == TC1_BASE + TC_COUNT_OFS);
        bad      = addr_ov_i || misalign || narrow || !legal;
        adel_o   = is_load && bad;
        ades_o   = is_store && (bad || cnt_hit);
    end

endmodule

// File: rtl/m_lsu.sv
// m_lsu: M-stage load/store unit. Holds the E/M register, drives the data
// bus request, resolves address exceptions and extends returning load data.
//   clk, reset_n    : clock, asynchronous active-low reset
//   flush           : squash; masks this cycle's write, loads a bubble
//   E_*             : E-stage instruction fields captured each edge
//   bus             : data-bus master (addr/wdata/byteen out, rdata in)
//   M_pc, M_exc     : registered PC and resolved ExcCode
//   M_load_data     : sign/zero-extended load result
module m_lsu
    import m_lsu_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        flush,
    input  logic        E_valid,
    input  logic [31:0] E_pc,
    input  logic [3:0]  E_mem_op,
    input  logic [31:0] E_addr,
    input  logic        E_addr_ov,
    input  logic [31:0] E_wdata,
    input  logic [4:0]  E_exc_in,
    m_lsu_if.master     bus,
    output logic [31:0] M_pc,
    output logic [4:0]  M_exc,
    output logic [31:0] M_load_data
);

    em_reg_t em_q, em_d;
    logic    adel, ades;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        em_d = '0;
        if (!flush) begin
            em_d.valid   = E_valid;
            em_d.pc      = E_pc;
            em_d.mem_op  = mem_op_e'(E_mem_op);
            em_d.addr    = E_addr;
            em_d.addr_ov = E_addr_ov;
            em_d.wdata   = E_wdata;
            em_d.exc_in  = E_exc_in;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) em_q <= '0;
        else          em_q <= em_d;
    end

    m_lsu_check u_check (
        .mem_op_i  (em_q.mem_op),
        .addr_i    (em_q.addr),
        .addr_ov_i (em_q.addr_ov),
        .adel_o    (adel),
        .ades_o    (ades)
    );

    always_comb begin
        if (em_q.exc_in != EXC_NONE)  M_exc = em_q.exc_in;
        else if (em_q.valid && adel)  M_exc = EXC_ADEL;
        else if (em_q.valid && ades)  M_exc = EXC_ADES;
        else                          M_exc = EXC_NONE;
    end

    always_comb begin
        bus.m_data_addr = em_q.addr;
        case (em_q.mem_op)
            MOP_SW: begin
                bus.m_data_byteen = 4'b1111;
                bus.m_data_wdata  = em_q.wdata;
            end
            MOP_SH: begin
                bus.m_data_byteen = 4'b0011 << {em_q.addr[1], 1'b0};
                bus.m_data_wdata  = {2{em_q.wdata[15:0]}};
            end
            MOP_SB: begin
                bus.m_data_byteen = 4'b0001 << em_q.addr[1:0];
                bus.m_data_wdata  = {4{em_q.wdata[7:0]}};
            end
            default: begin
                bus.m_data_byteen = 4'b0000;
                bus.m_data_wdata  = em_q.wdata;
            end
        endcase
        // flush is combinational here so the instruction being squashed never writes.
        if (!em_q.valid || (M_exc != EXC_NONE) || flush)
            bus.m_data_byteen = 4'b0000;
    end

    always_comb begin
        ld_byte = bus.m_data_rdata[{em_q.addr[1:0], 3'b000} +: 8];
        ld_half = em_q.addr[1] ? bus.m_data_rdata[31:16] : bus.m_data_rdata[15:0];
        case (em_q.mem_op)
            MOP_LW:  M_load_data = bus.m_data_rdata;
            MOP_LH:  M_load_data = {{16{ld_half[15]}}, ld_half};
            MOP_LHU: M_load_data = {16'h0000, ld_half};
            MOP_LB:  M_load_data = {{24{ld_byte[7]}}, ld_byte};
            MOP_LBU: M_load_data = {24'h000000, ld_byte};
            default: M_load_data = '0;
        endcase
    end

    assign M_pc = em_q.pc;

endmodule

// File: tb/tb_m_lsu.sv
module tb_m_lsu;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic        E_valid = 1'b0;
    logic [31:0] E_pc = '0;
    logic [3:0]  E_mem_op = '0;
    logic [31:0] E_addr = '0;
    logic        E_addr_ov = 1'b0;
    logic [31:0] E_wdata = '0;
    logic [4:0]  E_exc_in = '0;
    logic [31:0] M_pc;
    logic [4:0]  M_exc;
    logic [31:0] M_load_data;

    m_lsu_if bus_if ();

    m_lsu dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush       (flush),
        .E_valid     (E_valid),
        .E_pc        (E_pc),
        .E_mem_op    (E_mem_op),
        .E_addr      (E_addr),
        .E_addr_ov   (E_addr_ov),
        .E_wdata     (E_wdata),
        .E_exc_in    (E_exc_in),
        .bus         (bus_if),
        .M_pc        (M_pc),
        .M_exc       (M_exc),
        .M_load_data (M_load_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [4:0]  exc;
        logic [31:0] pc;
        logic [31:0] ld;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Drive one E-stage instruction at the falling edge and queue what M must show next cycle.
    task automatic apply(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         input logic ov, input logic [4:0] exc, input logic [31:0] pc,
                         input logic [31:0] rdata, input logic [3:0] xbe, input logic [31:0] xwd,
                         input logic [4:0] xexc, input logic [31:0] xld);
        @(negedge clk);
        E_valid = 1'b1; E_mem_op = op; E_addr = addr; E_wdata = wd;
        E_addr_ov = ov; E_exc_in = exc; E_pc = pc;
        bus_if.m_data_rdata = rdata;
        sb.push_back('{addr, xwd, xbe, xexc, pc, xld});
    endtask

    task automatic test_reset();
        exp_t e;
        E_valid = 1'b1; E_mem_op = 4'd6; E_addr = 32'h10; E_wdata = 32'hCAFE_F00D; E_pc = 32'h400;
        bus_if.m_data_rdata = 32'hFFFF_FFFF;
        sb.push_back('{32'h0, 32'h0, 4'h0, 5'd0, 32'h0, 32'h0});
        repeat (2) @(posedge clk);
        #1;
        e = sb.pop_front();
        vectors++; if (bus_if.m_data_byteen !== e.be) begin miscompares++; $display("FAIL reset_byteen got %h exp %h", bus_if.m_data_byteen, e.be); end
        vectors++; if (bus_if.m_data_addr !== e.addr) begin miscompares++; $display("FAIL reset_addr got %h exp %h", bus_if.m_data_addr, e.addr); end
        vectors++; if (M_exc !== e.exc) begin miscompares++; $display("FAIL reset_exc got %0d exp %0d", M_exc, e.exc); end
        vectors++; if (M_pc !== e.pc) begin miscompares++; $display("FAIL reset_pc got %h exp %h", M_pc, e.pc); end
        vectors++; if (M_load_data !== e.ld) begin miscompares++; $display("FAIL reset_ld got %h exp %h", M_load_data, e.ld); end
        @(negedge clk);
        reset_n = 1'b1;
        apply(4'd6, 32'h10, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h404, 32'h0, 4'hF, 32'hDEAD_BEEF, 5'd0, 32'h0);
        @(posedge clk); #1;
        e = sb.pop_front();
        vectors++; if (bus_if.m_data_byteen !== e.be) begin miscompares++; $display("FAIL first_sw_byteen got %h exp %h", bus_if.m_data_byteen, e.be); end
        vectors++; if (bus_if.m_data_wdata !== e.wdata) begin miscompares++; $display("FAIL first_sw_wdata got %h exp %h", bus_if.m_data_wdata, e.wdata); end
        vectors++; if (bus_if.m_data_addr !== e.addr) begin miscompares++; $display("FAIL first_sw_addr got %h exp %h", bus_if.m_data_addr, e.addr); end
        vectors++; if (M_pc !== e.pc) begin miscompares++; $display("FAIL first_sw_pc got %h exp %h", M_pc, e.pc); end
    endtask

    task automatic test_store_lanes();
        logic [3:0]  op [6] = '{4'd8, 4'd7, 4'd8, 4'd8, 4'd7, 4'd6};
        logic [31:0] ad [6] = '{32'h13, 32'h12, 32'h0, 32'h11, 32'h20, 32'h24};
        logic [31:0] wd [6] = '{32'h0000_00A5, 32'h0000_1234, 32'hFFFF_FF3C, 32'h0000_0077, 32'hABCD_5678, 32'h0102_0304};
        logic [3:0]  xb [6] = '{4'b1000, 4'b1100, 4'b0001, 4'b0010, 4'b0011, 4'b1111};
        logic [31:0] xw [6] = '{32'hA5A5_A5A5, 32'h1234_1234, 32'h3C3C_3C3C, 32'h7777_7777, 32'h5678_5678, 32'h0102_0304};
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            apply(op[i], ad[i], wd[i], 1'b0, 5'd0, 32'h800 + 32'(i * 4), 32'h0, xb[i], xw[i], 5'd0, 32'h0);
            @(posedge clk); #1;
            e = sb.pop_front();
            vectors++; if (bus_if.m_data_byteen !== e.be) begin miscompares++; $display("FAIL store%0d_byteen got %b exp %b", i, bus_if.m_data_byteen, e.be); end
            vectors++; if (bus_if.m_data_wdata !== e.wdata) begin miscompares++; $display("FAIL store%0d_wdata got %h exp %h", i, bus_if.m_data_wdata, e.wdata); end
            vectors++; if (bus_if.m_data_addr !== e.addr) begin miscompares++; $display("FAIL store%0d_addr got %h exp %h", i, bus_if.m_data_addr, e.addr); end
            vectors++; if (M_exc !== e.exc) begin miscompares++; $display("FAIL store%0d_exc got %0d exp %0d", i, M_exc, e.exc); end
        end
    endtask

    task automatic test_loads();
        logic [3:0]  op [9] = '{4'd4, 4'd5, 4'd4, 4'd5, 4'd2, 4'd3, 4'd1, 4'd4, 4'd2};
        logic [31:0] ad [9] = '{32'h2, 32'h2, 32'h3, 32'h3, 32'h2, 32'h2, 32'h0, 32'h0, 32'h0};
        logic [31:0] xl [9] = '{32'hFFFF_FFFF, 32'h0000_00FF, 32'hFFFF_FF80, 32'h0000_0080,
                                32'hFFFF_80FF, 32'h0000_80FF, 32'h80FF_7F01, 32'h0000_0001, 32'h0000_7F01};
        exp_t e;
        for (int i = 0; i < 9; i++) begin
            apply(op[i], ad[i], 32'h5555_5555, 1'b0, 5'd0, 32'h1000 + 32'(i * 4), 32'h80FF_7F01,
                  4'h0, 32'h0, 5'd0, xl[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            vectors++; if (M_load_data !== e.ld) begin miscompares++; $display("FAIL load%0d_data got %h exp %h", i, M_load_data, e.ld); end
            vectors++; if (bus_if.m_data_byteen !== e.be) begin miscompares++; $display("FAIL load%0d_byteen got %b exp %b", i, bus_if.m_data_byteen, e.be); end
            vectors++; if (M_exc !== e.exc) begin miscompares++; $display("FAIL load%0d_exc got %0d exp %0d", i, M_exc, e.exc); end
            vectors++; if (M_pc !== e.pc) begin miscompares++; $display("FAIL load%0d_pc got %h exp %h", i, M_pc, e.pc); end
        end
    endtask

    task automatic test_exceptions();
        logic [3:0]  op [14] = '{4'd1, 4'd6, 4'd4, 4'd6, 4'd6, 4'd6, 4'd6, 4'd6, 4'd7, 4'd1, 4'd1, 4'd2, 4'd8, 4'd6};
        logic [31:0] ad [14] = '{32'h3001, 32'h7F08, 32'h7F00, 32'h100, 32'h100, 32'h7F04, 32'h2FFC,
                                 32'h3000, 32'h7F20, 32'h7F18, 32'h7F1C, 32'h1, 32'h7F1B, 32'h7F24};
        logic        ov [14] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        logic [4:0]  ei [14] = '{0, 0, 0, 0, 10, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        logic [4:0]  xe [14] = '{4, 5, 4, 5, 10, 0, 0, 5, 0, 0, 4, 4, 5, 5};
        logic [3:0]  xb [14] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'hF, 4'h0, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        exp_t e;
        for (int i = 0; i < 14; i++) begin
            apply(op[i], ad[i], 32'h1357_9BDF, ov[i], ei[i], 32'h2000 + 32'(i * 4), 32'h0,
                  xb[i], 32'h0, xe[i], 32'h0);
            @(posedge clk); #1;
            e = sb.pop_front();
            vectors++; if (M_exc !== e.exc) begin miscompares++; $display("FAIL exc%0d_code got %0d exp %0d", i, M_exc, e.exc); end
            vectors++; if (bus_if.m_data_byteen !== e.be) begin miscompares++; $display("FAIL exc%0d_byteen got %b exp %b", i, bus_if.m_data_byteen, e.be); end
        end
    endtask

    task automatic test_flush();
        exp_t e;
        apply(4'd6, 32'h20, 32'h1122_3344, 1'b0, 5'd0, 32'h600, 32'h0, 4'hF, 32'h1122_3344, 5'd0, 32'h0);
        @(posedge clk); #1;
        e = sb.pop_front();
        vectors++; if (bus_if.m_data_byteen !== e.be) begin miscompares++; $display("FAIL preflush_byteen got %b exp %b", bus_if.m_data_byteen, e.be); end
        flush = 1'b1;
        sb.push_back('{32'h20, 32'h1122_3344, 4'h0, 5'd0, 32'h600, 32'h0});
        #1;
        e = sb.pop_front();
        vectors++; if (bus_if.m_data_byteen !== e.be) begin miscompares++; $display("FAIL flush_mask_byteen got %b exp %b", bus_if.m_data_byteen, e.be); end
        @(negedge clk);
        E_valid = 1'b1; E_mem_op = 4'd6; E_addr = 32'h24; E_pc = 32'h700; E_exc_in = 5'd10;
        sb.push_back('{32'h0, 32'h0, 4'h0, 5'd0, 32'h0, 32'h0});
        @(posedge clk); #1;
        flush = 1'b0;
        #1;
        e = sb.pop_front();
        vectors++; if (M_pc !== e.pc) begin miscompares++; $display("FAIL bubble_pc got %h exp %h", M_pc, e.pc); end
        vectors++; if (M_exc !== e.exc) begin miscompares++; $display("FAIL bubble_exc got %0d exp %0d", M_exc, e.exc); end
        vectors++; if (bus_if.m_data_byteen !== e.be) begin miscompares++; $display("FAIL bubble_byteen got %b exp %b", bus_if.m_data_byteen, e.be); end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  op [3] = '{4'd6, 4'd8, 4'd1};
        logic [31:0] ad [3] = '{32'h0, 32'h1, 32'h4};
        logic [31:0] wd [3] = '{32'hA0A1_A2A3, 32'h0000_00C7, 32'h0};
        logic [3:0]  xb [3] = '{4'b1111, 4'b0010, 4'b0000};
        logic [31:0] xl [3] = '{32'h0, 32'h0, 32'h8765_4321};
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            apply(op[i], ad[i], wd[i], 1'b0, 5'd0, 32'h3000 + 32'(i * 4), 32'h8765_4321,
                  xb[i], 32'h0, 5'd0, xl[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            vectors++; if (M_pc !== e.pc) begin miscompares++; $display("FAIL b2b%0d_pc got %h exp %h", i, M_pc, e.pc); end
            vectors++; if (bus_if.m_data_addr !== e.addr) begin miscompares++; $display("FAIL b2b%0d_addr got %h exp %h", i, bus_if.m_data_addr, e.addr); end
            vectors++; if (bus_if.m_data_byteen !== e.be) begin miscompares++; $display("FAIL b2b%0d_byteen got %b exp %b", i, bus_if.m_data_byteen, e.be); end
            vectors++; if (M_load_data !== e.ld) begin miscompares++; $display("FAIL b2b%0d_ld got %h exp %h", i, M_load_data, e.ld); end
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        apply(4'd6, 32'h40, 32'h0BAD_F00D, 1'b0, 5'd0, 32'h500, 32'h0, 4'hF, 32'h0BAD_F00D, 5'd0, 32'h0);
        @(posedge clk); #1;
        e = sb.pop_front();
        vectors++; if (M_pc !== e.pc) begin miscompares++; $display("FAIL prerst_pc got %h exp %h", M_pc, e.pc); end
        #2;
        reset_n = 1'b0;
        sb.push_back('{32'h0, 32'h0, 4'h0, 5'd0, 32'h0, 32'h0});
        #1;
        e = sb.pop_front();
        vectors++; if (M_pc !== e.pc) begin miscompares++; $display("FAIL asyncrst_pc got %h exp %h", M_pc, e.pc); end
        vectors++; if (bus_if.m_data_byteen !== e.be) begin miscompares++; $display("FAIL asyncrst_byteen got %b exp %b", bus_if.m_data_byteen, e.be); end
        vectors++; if (bus_if.m_data_addr !== e.addr) begin miscompares++; $display("FAIL asyncrst_addr got %h exp %h", bus_if.m_data_addr, e.addr); end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        vectors++; if (M_pc !== 32'h0) begin miscompares++; $display("FAIL postrel_pc got %h exp %h", M_pc, 32'h0); end
        @(posedge clk); #1;
        vectors++; if (M_pc !== 32'h500) begin miscompares++; $display("FAIL firstedge_pc got %h exp %h", M_pc, 32'h500); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        bus_if.m_data_rdata = '0;
        test_reset();
        test_store_lanes();
        test_loads();
        test_exceptions();
        test_flush();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
